mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the processor's single-port unified word memory. It shares the memory between the instruction-fetch requester (IF) and the load/store requester (LS). It captures each request, drives one memory access cycle and returns registered read data with a one-cycle acknowledge. It sits between the multi-cycle control/datapath and the `Memory` block: it drives `Address`, `Write_Data` and `Write_Enable`, and receives `Read_Data`.

## Interface
- `DATA_W`, 32, data width of memory words and requester data.
- `ADDR_W`, 32, byte-address width; passed through unmodified, word select is done by memory.
- `MAX_LS_STREAK`, 2, consecutive LS grants allowed while IF is waiting before IF is forced; range 1..15.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held high with `if_addr` stable until `if_ack`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_ack`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid this cycle.
- `if_rdata`  out  DATA_W  fetched word, held until next IF completion.
- `ls_req`  in  1  load/store request; held with `ls_we`/`ls_addr`/`ls_wdata` stable until `ls_ack`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  ADDR_W  load/store byte address.
- `ls_wdata`  in  DATA_W  store data.
- `ls_ack`  out  1  one-cycle pulse: access complete; for loads `ls_rdata` valid.
- `ls_rdata`  out  DATA_W  loaded word, held until next LS load completion.
- `mem_addr`  out  ADDR_W  to memory `Address`.
- `mem_wdata`  out  DATA_W  to memory `Write_Data`.
- `mem_we`  out  1  to memory `Write_Enable`.
- `mem_rdata`  in  DATA_W  from memory `Read_Data` (combinational read).
- `busy`  out  1  high in any state other than IDLE.
- `grant_ls`  out  1  owner of current/last access: 1 = LS, 0 = IF.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request present: select an owner and latch that requester's addr/wdata/we into internal registers. Set `grant_ls`; go to ACCESS.
- ACCESS: `mem_addr`/`mem_wdata` driven from the latched registers. `mem_we` = latched we AND owner is LS. On exit edge, `mem_rdata` is captured into `if_rdata` (IF) or `ls_rdata` (LS load only); go to DONE.
- DONE: assert the owner's ack for exactly this cycle; go to IDLE. Requests are not evaluated in DONE.
- Arbitration, evaluated in IDLE only:
  - LS alone gets LS; IF alone gets IF.
  - When both request, LS wins unless `ls_streak == MAX_LS_STREAK`, in which case IF wins.
- `ls_streak` (4 bits) update at each grant:
  - +1 when LS is granted while `if_req` is high, saturating at `MAX_LS_STREAK`.
  - Cleared to 0 when IF is granted, or when LS is granted with `if_req` low.
- Outputs outside ACCESS:
  - `mem_we` = 0.
  - `mem_addr`/`mem_wdata` hold the latched values.
- IF stores are impossible; `ls_we` is ignored for IF.
- LS store completion leaves `ls_rdata` unchanged.

## Timing
- Reset (rst low, asynchronous):
  - State = IDLE.
  - `if_ack` = `ls_ack` = `mem_we` = `busy` = `grant_ls` = 0.
  - `mem_addr` = `mem_wdata` = `if_rdata` = `ls_rdata` = 0.
  - `ls_streak` = 0.
- Latency: request seen high at edge N (state IDLE) → ACCESS in cycle N+1 → ack in cycle N+2. Three cycles per access minimum; back-to-back throughput is one access per 3 cycles.
- A requester may keep its req high in the cycle after its ack; that is a new request, sampled in the following IDLE cycle.
- A requester's inputs are sampled only at the IDLE→ACCESS edge. Later changes have no effect on the current access.
- Reset asserted during ACCESS:
  - `mem_we` drops immediately, so no write occurs at the following edge.
  - The pending ack is never issued.
  - The requester must re-request after reset.
- Reset during DONE: the ack is cut short; data registers clear to 0.

## Test plan
- Reset: hold rst low 3 cycles with `if_req` = `ls_req` = 1 → all outputs 0, no ack, `mem_we` never 1.
- IF read: memory word 3 = 0xDEADBEEF, `if_req` = 1, `if_addr` = 0x0C at cycle 0 → `mem_addr` = 0x0C in cycle 1, `if_ack` = 1 with `if_rdata` = 0xDEADBEEF in cycle 2, `busy` low in cycle 3.
- LS store then load:
  - Store 0x12345678 to 0x40 → `mem_we` high for exactly one cycle and `ls_rdata` unchanged.
  - Then load 0x40 → `ls_rdata` = 0x12345678.
- Contention, `MAX_LS_STREAK` = 2: `if_req` and `ls_req` held high continuously → grant order LS, LS, IF, LS, LS, IF with acks every 3 cycles.
- Reset mid-store: assert rst low in the ACCESS cycle of a store of 0xFFFFFFFF to 0x80 (previously 0) → after release, a load of 0x80 returns 0 and no `ls_ack` is seen for the aborted store.
- Input change after grant: alter `ls_addr` from 0x10 to 0x20 during ACCESS → the access uses 0x10.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for a single-port unified word memory.
// Shares the memory between instruction fetch (IF) and load/store (LS).
// Each access runs IDLE -> ACCESS -> DONE, so it takes three cycles.
// The requester's inputs are latched on the IDLE->ACCESS edge.
// The owner's ack is a one-cycle pulse in DONE.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   if_req/if_addr      fetch request and byte address
//   if_ack/if_rdata     fetch completion pulse and fetched word (held)
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, store flag, address, data
//   ls_ack/ls_rdata     load/store completion pulse and loaded word (held)
//   mem_addr/mem_wdata/mem_we      memory Address / Write_Data / Write_Enable
//   mem_rdata           memory Read_Data (combinational read)
//   busy                high whenever the sequencer is not idle
//   grant_ls            owner of current/last access (1 = LS, 0 = IF)
module mem_arbiter #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int MAX_LS_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_ls
);

  localparam logic [3:0] MAX_STREAK_C = 4'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        streak_r;
  logic              we_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] ls_rdata_r;
  logic              if_ack_r;
  logic              ls_ack_r;
  logic              busy_r;
  logic              grant_ls_r;

  logic              pick_ls_s;
  logic [3:0]        next_streak_s;

  // Arbitration decision and the streak value to store if a grant happens now
  always_comb begin
    pick_ls_s     = 1'b0;
    next_streak_s = 4'd0;
    // LS wins unless IF is waiting and LS has used up its streak allowance
    if (ls_req && (!if_req || (streak_r != MAX_STREAK_C))) begin
      pick_ls_s = 1'b1;
    end else begin
      pick_ls_s = 1'b0;
    end
    // Only LS grants that make IF wait extend the streak
    if (pick_ls_s && if_req) begin
      if (streak_r >= MAX_STREAK_C) begin
        next_streak_s = MAX_STREAK_C;
      end else begin
        next_streak_s = streak_r + 4'd1;
      end
    end else begin
      next_streak_s = 4'd0;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      streak_r   <= 4'd0;
      we_r       <= 1'b0;
      mem_we_r   <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      if_rdata_r <= '0;
      ls_rdata_r <= '0;
      if_ack_r   <= 1'b0;
      ls_ack_r   <= 1'b0;
      busy_r     <= 1'b0;
      grant_ls_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_ack_r <= 1'b0;
          ls_ack_r <= 1'b0;
          if (if_req || ls_req) begin
            state_r    <= ST_ACCESS;
            busy_r     <= 1'b1;
            grant_ls_r <= pick_ls_s;
            streak_r   <= next_streak_s;
            if (pick_ls_s) begin
              addr_r   <= ls_addr;
              wdata_r  <= ls_wdata;
              we_r     <= ls_we;
              mem_we_r <= ls_we;
            end else begin
              // Fetches never write; the previous write data is simply left in place
              addr_r   <= if_addr;
              we_r     <= 1'b0;
              mem_we_r <= 1'b0;
            end
          end else begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            mem_we_r <= 1'b0;
          end
        end
        ST_ACCESS: begin
          state_r  <= ST_DONE;
          mem_we_r <= 1'b0;
          if (grant_ls_r) begin
            ls_ack_r <= 1'b1;
            if_ack_r <= 1'b0;
            // A store must not disturb the last loaded word
            if (!we_r) begin
              ls_rdata_r <= mem_rdata;
            end else begin
              ls_rdata_r <= ls_rdata_r;
            end
          end else begin
            if_ack_r   <= 1'b1;
            ls_ack_r   <= 1'b0;
            if_rdata_r <= mem_rdata;
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          if_ack_r <= 1'b0;
          ls_ack_r <= 1'b0;
          busy_r   <= 1'b0;
          mem_we_r <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          if_ack_r <= 1'b0;
          ls_ack_r <= 1'b0;
          busy_r   <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_r;
  assign if_rdata  = if_rdata_r;
  assign ls_ack    = ls_ack_r;
  assign ls_rdata  = ls_rdata_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;
  assign grant_ls  = grant_ls_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. It holds a behavioural
// memory, directed scenarios and a randomized requester loop. The loop is checked
// against a transaction-level model of the arbitration and data rules.
module tb_mem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAX = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr, mem_addr;
  logic [DW-1:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic          if_ack, ls_ack, mem_we, busy, grant_ls;

  // backdoor preload port into the memory model
  logic          bd_we;
  logic [7:0]    bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] exp_mem [0:255];
  logic [DW-1:0] exp_if_rdata, exp_ls_rdata;
  int            streak_m;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // single-port memory: combinational read, write on the clock edge
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LS_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .grant_ls(grant_ls)
  );

  task automatic wait_ack(output logic got_if, output logic got_ls, output logic timed_out);
    got_if = 1'b0; got_ls = 1'b0; timed_out = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_ack || ls_ack) begin
        got_if = if_ack; got_ls = ls_ack; timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic preload();
    logic [DW-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      if (i == 3)  v = 32'hDEADBEEF;
      if (i == 4)  v = 32'hA5A50010;
      if (i == 8)  v = 32'h5A5A0020;
      if (i == 32) v = 32'h00000000;
      exp_mem[i] = v;
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 8'(i); bd_data = v;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; ls_req = 1'b1; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({if_ack, ls_ack, mem_we, busy, grant_ls} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl: got %b required 00000", {if_ack, ls_ack, mem_we, busy, grant_ls});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_data: addr %h wdata %h if_rdata %h ls_rdata %h, required all 0",
                 mem_addr, mem_wdata, if_rdata, ls_rdata);
      end
    end
    if_req = 1'b0; ls_req = 1'b0; rst = 1'b1;
    exp_if_rdata = '0; exp_ls_rdata = '0; streak_m = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_if_read();
    if_addr = 32'h0000000C; if_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_addr, busy, if_ack} !== {32'h0000000C, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL if_read_c1: addr %h busy %b ack %b, required 0000000c 1 0", mem_addr, busy, if_ack);
    end
    @(negedge clk);
    n_checks++;
    if ({if_ack, ls_ack, grant_ls, if_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL if_read_c2: if_ack %b ls_ack %b grant_ls %b rdata %h, required 1 0 0 deadbeef",
                         if_ack, ls_ack, grant_ls, if_rdata);
    end
    if_req = 1'b0; exp_if_rdata = 32'hDEADBEEF; streak_m = 0;
    @(negedge clk);
    n_checks++;
    if ({busy, if_ack} !== 2'b00) begin
      n_fail++; $display("FAIL if_read_c3: busy %b ack %b, required 0 0", busy, if_ack);
    end
  endtask

  task automatic test_store_load();
    int   we_cnt;
    logic seen, gi, gl, to;
    we_cnt = 0; seen = 1'b0;
    ls_we = 1'b1; ls_addr = 32'h00000040; ls_wdata = 32'h12345678; ls_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_we === 1'b1) we_cnt++;
      if (ls_ack === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++;
    if ({seen, we_cnt} !== {1'b1, 32'd1}) begin
      n_fail++; $display("FAIL store_we: ack_seen %b we_cycles %0d, required 1 and 1", seen, we_cnt);
    end
    n_checks++;
    if (ls_rdata !== exp_ls_rdata) begin
      n_fail++; $display("FAIL store_rdata_kept: got %h required %h", ls_rdata, exp_ls_rdata);
    end
    exp_mem[16] = 32'h12345678;
    ls_req = 1'b0;
    @(negedge clk);
    ls_we = 1'b0; ls_req = 1'b1;
    wait_ack(gi, gl, to);
    n_checks++;
    if ({to, gi, gl, ls_rdata} !== {1'b0, 1'b0, 1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL load_after_store: timeout %b if_ack %b ls_ack %b rdata %h, required 0 0 1 12345678",
                         to, gi, gl, ls_rdata);
    end
    exp_ls_rdata = 32'h12345678;
    ls_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic       gi, gl, to, exp_ls;
    int         last;
    logic [5:0] order;
    order = '0; last = 0;
    if_addr = 32'h0000000C; ls_addr = 32'h00000040; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_ls = (streak_m != MAX);
      wait_ack(gi, gl, to);
      order = {order[4:0], gl};
      n_checks++;
      if ({to, gi, gl, grant_ls} !== {1'b0, !exp_ls, exp_ls, exp_ls}) begin
        n_fail++; $display("FAIL contention_grant%0d: timeout %b if_ack %b ls_ack %b grant_ls %b, required 0 %b %b %b",
                           n, to, gi, gl, grant_ls, !exp_ls, exp_ls, exp_ls);
      end
      if (n > 0) begin
        n_checks++;
        if (cyc - last !== 3) begin
          n_fail++; $display("FAIL contention_spacing%0d: got %0d cycles required 3", n, cyc - last);
        end
      end
      last = cyc;
      n_checks++;
      if ((exp_ls ? ls_rdata : if_rdata) !== (exp_ls ? exp_mem[16] : exp_mem[3])) begin
        n_fail++; $display("FAIL contention_data%0d: got %h required %h", n,
                           exp_ls ? ls_rdata : if_rdata, exp_ls ? exp_mem[16] : exp_mem[3]);
      end
      if (exp_ls) streak_m = (streak_m + 1 > MAX) ? MAX : streak_m + 1;
      else        streak_m = 0;
    end
    n_checks++;
    if (order !== 6'b110110) begin
      n_fail++; $display("FAIL contention_order: got %b required 110110 (1=LS)", order);
    end
    if_req = 1'b0; ls_req = 1'b0;
    exp_if_rdata = exp_mem[3]; exp_ls_rdata = exp_mem[16];
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    int   acks;
    logic gi, gl, to;
    acks = 0;
    ls_we = 1'b1; ls_addr = 32'h00000080; ls_wdata = 32'hFFFFFFFF; ls_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++; $display("FAIL midstore_we_on: got %b required 1", mem_we);
    end
    rst = 1'b0; ls_req = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, busy} !== 2'b00) begin
      n_fail++; $display("FAIL midstore_we_drop: mem_we %b busy %b, required 0 0", mem_we, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_if_rdata = '0; exp_ls_rdata = '0; streak_m = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ls_ack === 1'b1) acks++;
    end
    n_checks++;
    if ({acks, if_rdata, ls_rdata} !== {32'd0, exp_if_rdata, exp_ls_rdata}) begin
      n_fail++; $display("FAIL midstore_no_ack: acks %0d if_rdata %h ls_rdata %h, required 0 0 0",
                         acks, if_rdata, ls_rdata);
    end
    ls_we = 1'b0; ls_req = 1'b1;
    wait_ack(gi, gl, to);
    n_checks++;
    if ({to, gl, ls_rdata} !== {1'b0, 1'b1, exp_mem[32]}) begin
      n_fail++; $display("FAIL midstore_reload: timeout %b ls_ack %b rdata %h, required 0 1 %h",
                         to, gl, ls_rdata, exp_mem[32]);
    end
    exp_ls_rdata = exp_mem[32];
    ls_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_input_change();
    logic gi, gl, to;
    ls_we = 1'b0; ls_addr = 32'h00000010; ls_req = 1'b1;
    @(negedge clk);
    ls_addr = 32'h00000020;
    n_checks++;
    if (mem_addr !== 32'h00000010) begin
      n_fail++; $display("FAIL input_change_addr: got %h required 00000010", mem_addr);
    end
    wait_ack(gi, gl, to);
    n_checks++;
    if ({to, gl, ls_rdata} !== {1'b0, 1'b1, exp_mem[4]}) begin
      n_fail++; $display("FAIL input_change_data: timeout %b ls_ack %b rdata %h, required 0 1 %h",
                         to, gl, ls_rdata, exp_mem[4]);
    end
    exp_ls_rdata = exp_mem[4];
    ls_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic pif, pls, win_ls, gi, gl, to;
    int   done_cnt, guard;
    pif = 1'b0; pls = 1'b0; done_cnt = 0; guard = 0;
    while (done_cnt < 60 && guard < 400) begin
      guard++;
      if (!pif && ($urandom_range(0, 1) == 1)) begin
        pif = 1'b1; if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!pls && ($urandom_range(0, 1) == 1)) begin
        pls = 1'b1; ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
        ls_addr = 32'($urandom_range(0, 15)) << 2; ls_wdata = $urandom;
      end
      if (!pif && !pls) begin
        @(negedge clk);
        continue;
      end
      win_ls = pls && (!pif || streak_m != MAX);
      wait_ack(gi, gl, to);
      n_checks++;
      if ({to, gi, gl} !== {1'b0, !win_ls, win_ls}) begin
        n_fail++; $display("FAIL random_grant%0d: timeout %b if_ack %b ls_ack %b, required 0 %b %b",
                           done_cnt, to, gi, gl, !win_ls, win_ls);
      end
      if (win_ls) begin
        if (ls_we) exp_mem[ls_addr[9:2]] = ls_wdata;
        else       exp_ls_rdata = exp_mem[ls_addr[9:2]];
        streak_m = pif ? ((streak_m + 1 > MAX) ? MAX : streak_m + 1) : 0;
        pls = 1'b0; ls_req = 1'b0;
      end else begin
        exp_if_rdata = exp_mem[if_addr[9:2]];
        streak_m = 0;
        pif = 1'b0; if_req = 1'b0;
      end
      n_checks++;
      if ({if_rdata, ls_rdata} !== {exp_if_rdata, exp_ls_rdata}) begin
        n_fail++; $display("FAIL random_data%0d: if_rdata %h ls_rdata %h, required %h %h",
                           done_cnt, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
      end
      done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 60) begin
      n_fail++; $display("FAIL random_count: got %0d transactions required 60", done_cnt);
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    exp_if_rdata = '0; exp_ls_rdata = '0; streak_m = 0;
    preload();
    test_reset();
    test_if_read();
    test_store_load();
    test_contention();
    test_reset_mid_store();
    test_input_change();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
